// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mc_pkg;

    // Controller states (4-bit encoding)
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // FSM-to-decoder ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct onto a 3-bit ALU control code.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Unknown funct codes and the unused alu_op value fall back to add
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle MIPS datapath; drives all mux selects/enables.
// Latency: 2-5 cycles per instruction; outputs decode from the current state.
// Backpressure: none; reset abandons the current instruction and masks all write enables.
module multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int INST_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done
);

    // op and funct are sliced out of IR[31:26] and IR[5:0] upstream
    if (INST_WIDTH != 32) begin : g_inst_width_check
        $error("multicycle_controller expects a 32-bit instruction word");
    end

    state_t     state;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;

    // State register and next-state selection
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BEQ;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: state <= S_MEMWB;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; unlisted controls stay 0 and the ALU adds
    always_comb begin
        pc_write      = 1'b0;
        branch        = 1'b0;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_src        = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        done_raw      = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                pc_write     = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                alu_src_b = SRCB_IMM_SH;
                done_raw  = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: iord = 1'b1;
            S_MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                done_raw  = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // Reset masks every state-changing strobe so an abandoned instruction leaves no trace
    assign pc_en      = !reset && (pc_write || (branch && zero));
    assign mem_write  = !reset && mem_write_raw;
    assign ir_write   = !reset && ir_write_raw;
    assign reg_write  = !reset && reg_write_raw;
    assign instr_done = !reset && done_raw;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output words against hand-built constants.
// Latency: one check per clock, sampled on the falling edge.
// Backpressure: n/a.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       instr_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.INST_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .instr_done  (instr_done)
    );

    // Output word: pc_en iord mem_write ir_write reg_write reg_dst mem_to_reg alu_src_a
    //              alu_src_b[1:0] pc_src[1:0] alu_control[2:0] instr_done
    wire [15:0] obs = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, pc_src, alu_control, instr_done};

    localparam logic [15:0] FULL     = 16'hFFFF;
    localparam logic [15:0] ENA_MASK = {1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1};

    localparam logic [15:0] W_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b0};
    localparam logic [15:0] W_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b0};
    localparam logic [15:0] W_DEC_NOP = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b1};
    localparam logic [15:0] W_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,1'b0};
    localparam logic [15:0] W_MEMREAD = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0};
    localparam logic [15:0] W_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b010,1'b1};
    localparam logic [15:0] W_MEMWR   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b1};
    localparam logic [15:0] W_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b010,1'b1};
    localparam logic [15:0] W_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b1};
    localparam logic [15:0] W_BEQ_T   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,1'b1};
    localparam logic [15:0] W_BEQ_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,1'b1};
    localparam logic [15:0] W_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b010,1'b1};

    // EXECUTE word with the given ALU code
    function automatic logic [15:0] w_exec(input logic [2:0] alu);
        return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,alu,1'b0};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare on the falling edge, step past the rising edge
    task automatic cyc(input string tag, input logic [5:0] op_v, input logic [5:0] fn_v,
                       input logic z_v, input logic [15:0] exp, input logic [15:0] mask);
        op    = op_v;
        funct = fn_v;
        zero  = z_v;
        @(negedge clk);
        check(tag, obs & mask, exp & mask);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] rfn  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
    logic [2:0] ralu [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        cyc("por_rst1", 6'h00, 6'h00, 1'b0, 16'h0000, ENA_MASK);
        cyc("por_rst2", 6'h00, 6'h00, 1'b0, 16'h0000, ENA_MASK);
        reset = 1'b0;

        // lw: 5 cycles
        cyc("lw_fetch",   6'h23, 6'h00, 1'b0, W_FETCH,   FULL);
        cyc("lw_decode",  6'h23, 6'h00, 1'b0, W_DECODE,  FULL);
        cyc("lw_memadr",  6'h23, 6'h00, 1'b0, W_MEMADR,  FULL);
        cyc("lw_memread", 6'h23, 6'h00, 1'b0, W_MEMREAD, FULL);
        cyc("lw_memwb",   6'h23, 6'h00, 1'b0, W_MEMWB,   FULL);

        // sw: 4 cycles, then back to FETCH
        cyc("sw_fetch",   6'h2B, 6'h00, 1'b0, W_FETCH,   FULL);
        cyc("sw_decode",  6'h2B, 6'h00, 1'b0, W_DECODE,  FULL);
        cyc("sw_memadr",  6'h2B, 6'h00, 1'b0, W_MEMADR,  FULL);
        cyc("sw_memwr",   6'h2B, 6'h00, 1'b0, W_MEMWR,   FULL);

        // R-type funct sweep, including an unknown funct
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("r%0d_fetch", i),  6'h00, rfn[i], 1'b0, W_FETCH,          FULL);
            cyc($sformatf("r%0d_decode", i), 6'h00, rfn[i], 1'b0, W_DECODE,         FULL);
            cyc($sformatf("r%0d_exec", i),   6'h00, rfn[i], 1'b0, w_exec(ralu[i]),  FULL);
            cyc($sformatf("r%0d_aluwb", i),  6'h00, rfn[i], 1'b0, W_ALUWB,          FULL);
        end

        // beq taken and not taken: 3 cycles each
        cyc("beqt_fetch",  6'h04, 6'h00, 1'b1, W_FETCH,  FULL);
        cyc("beqt_decode", 6'h04, 6'h00, 1'b1, W_DECODE, FULL);
        cyc("beqt_beq",    6'h04, 6'h00, 1'b1, W_BEQ_T,  FULL);
        cyc("beqn_fetch",  6'h04, 6'h00, 1'b0, W_FETCH,  FULL);
        cyc("beqn_decode", 6'h04, 6'h00, 1'b0, W_DECODE, FULL);
        cyc("beqn_beq",    6'h04, 6'h00, 1'b0, W_BEQ_N,  FULL);

        // addi: 4 cycles
        cyc("addi_fetch",  6'h08, 6'h00, 1'b0, W_FETCH,   FULL);
        cyc("addi_decode", 6'h08, 6'h00, 1'b0, W_DECODE,  FULL);
        cyc("addi_ex",     6'h08, 6'h00, 1'b0, W_MEMADR,  FULL);
        cyc("addi_wb",     6'h08, 6'h00, 1'b0, W_ADDIWB,  FULL);

        // j: 3 cycles
        cyc("j_fetch",  6'h02, 6'h00, 1'b0, W_FETCH,  FULL);
        cyc("j_decode", 6'h02, 6'h00, 1'b0, W_DECODE, FULL);
        cyc("j_jump",   6'h02, 6'h00, 1'b0, W_JUMP,   FULL);

        // illegal opcode: 2 cycles, done pulses in DECODE
        cyc("ill_fetch",  6'h3F, 6'h00, 1'b0, W_FETCH,   FULL);
        cyc("ill_decode", 6'h3F, 6'h00, 1'b0, W_DEC_NOP, FULL);

        // Reset for 2 cycles while an R-type sits in EXECUTE
        cyc("mid_fetch",  6'h00, 6'h22, 1'b1, W_FETCH,  FULL);
        cyc("mid_decode", 6'h00, 6'h22, 1'b1, W_DECODE, FULL);
        reset = 1'b1;
        cyc("mid_rst1",   6'h00, 6'h22, 1'b1, 16'h0000, ENA_MASK);
        cyc("mid_rst2",   6'h00, 6'h22, 1'b1, 16'h0000, ENA_MASK);
        reset = 1'b0;
        cyc("post_fetch",  6'h00, 6'h22, 1'b0, W_FETCH,               FULL);
        cyc("post_decode", 6'h00, 6'h22, 1'b0, W_DECODE,              FULL);
        cyc("post_exec",   6'h00, 6'h22, 1'b0, w_exec(3'b110),        FULL);
        cyc("post_aluwb",  6'h00, 6'h22, 1'b0, W_ALUWB,               FULL);
        cyc("post_fetch2", 6'h00, 6'h00, 1'b0, W_FETCH,               FULL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
